// File: rtl/svn_seg_pkg.sv
// Shared types and constants for the multiplexed 7-segment scan driver.
// Segment byte layout: bit7 = DP, bits6:0 = g..a, active-high before polarity.
package svn_seg_pkg;

    typedef enum logic {
        BLANK,
        ON
    } seg_state_e;

    localparam logic [7:0] SEG_OFF = 8'h00;

    // Index 0 is the rightmost entry: glyphs 0-9, A, b, C, d, E, F.
    localparam bit [15:0][7:0] SEG7_HEX = {
        8'h71, 8'h79, 8'h5E, 8'h39,
        8'h7C, 8'h77, 8'h6F, 8'h7F,
        8'h07, 8'h7D, 8'h6D, 8'h66,
        8'h4F, 8'h5B, 8'h06, 8'h3F
    };

endpackage

// File: rtl/svn_seg_decode.sv
// Combinational hex-to-segment decoder with DP merge, blanking and
// output polarity applied last.
module svn_seg_decode
    import svn_seg_pkg::*;
#(
    parameter bit LED_POLARITY = 1'b0
) (
    input  logic [3:0] nibble,
    input  logic       dp,
    input  logic       blank,
    output logic [7:0] seg
);

    logic [7:0] raw;

    always_comb begin
        raw    = blank ? SEG_OFF : SEG7_HEX[nibble];
        raw[7] = raw[7] | dp;
        seg    = LED_POLARITY ? raw : ~raw;
    end

endmodule

// File: rtl/svn_seg_scan.sv
// Multiplexed 7-segment scan driver with tear-free frame buffering.
// Define SVN_SEG_LZ_BLANK_EN to enable leading-zero blanking.
module svn_seg_scan
    import svn_seg_pkg::*;
#(
    parameter int CLK_IN_MHZ   = 125,
    parameter bit LED_POLARITY = 1'b0,
    parameter int NUM_DIGITS   = 3,
    parameter int REFRESH_HZ   = 1000,
    parameter int DEAD_CYCLES  = 8
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [4*NUM_DIGITS-1:0] data_i,
    input  logic [NUM_DIGITS-1:0]   dp_i,
    input  logic                    valid_i,
    output logic                    ready_o,
    output logic [7:0]              seg_display_o,
    output logic [NUM_DIGITS-1:0]   seg_sel_o
);

    localparam int TICK  = CLK_IN_MHZ * 1000000 / REFRESH_HZ;
    localparam int CNT_W = $clog2(TICK);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int DW    = 4 * NUM_DIGITS;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK - 1);
    localparam logic [CNT_W-1:0] CNT_ON   = CNT_W'(DEAD_CYCLES);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
    localparam logic [7:0]       PIN_OFF  =
        LED_POLARITY ? SEG_OFF : ~SEG_OFF;

    if (TICK <= DEAD_CYCLES + 1) begin : g_tick_chk
        $error("svn_seg_scan: TICK must exceed DEAD_CYCLES+1");
    end

    seg_state_e            state;
    logic [CNT_W-1:0]      cnt;
    logic [IDX_W-1:0]      idx;
    logic [DW-1:0]         act_data;
    logic [NUM_DIGITS-1:0] act_dp;
    logic [DW-1:0]         pend_data;
    logic [NUM_DIGITS-1:0] pend_dp;
    logic                  pend_full;

    logic       slot_end;
    logic       wrap;
    logic       load;
    logic       take;
    logic       pend_full_nxt;
    logic       lit;
    logic       cur_blank;
    logic [7:0] dec_seg;

`ifdef SVN_SEG_LZ_BLANK_EN
    logic [NUM_DIGITS-1:0] lz_mask;

    // Digit k is blank when it and every more significant nibble is zero.
    function automatic logic [NUM_DIGITS-1:0] lz_of(
        input logic [DW-1:0] w
    );
        logic zero;
        lz_of = '0;
        zero  = 1'b1;
        for (int k = NUM_DIGITS - 1; k > 0; k--) begin
            zero     = zero && (w[4*k +: 4] == 4'h0);
            lz_of[k] = zero;
        end
    endfunction

    assign cur_blank = lz_mask[idx];
`else
    assign cur_blank = 1'b0;
`endif

    assign slot_end      = (cnt == CNT_LAST);
    assign wrap          = slot_end && (idx == IDX_LAST);
    assign load          = wrap && pend_full;
    assign take          = valid_i && ready_o;
    assign pend_full_nxt = (pend_full && !load) || take;
    // The last ON cycle is dropped so the dead gap starts on the pins.
    assign lit           = (state == ON) && !slot_end;

    svn_seg_decode #(
        .LED_POLARITY (LED_POLARITY)
    ) u_decode (
        .nibble (act_data[{idx, 2'b00} +: 4]),
        .dp     (act_dp[idx]),
        .blank  (cur_blank),
        .seg    (dec_seg)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state         <= BLANK;
            cnt           <= '0;
            idx           <= '0;
            act_data      <= '0;
            act_dp        <= '0;
            pend_data     <= '0;
            pend_dp       <= '0;
            pend_full     <= 1'b0;
            ready_o       <= 1'b0;
            seg_sel_o     <= '0;
            seg_display_o <= PIN_OFF;
`ifdef SVN_SEG_LZ_BLANK_EN
            lz_mask       <= lz_of('0);
`endif
        end else begin
            ready_o   <= !pend_full_nxt;
            pend_full <= pend_full_nxt;
            if (load) begin
                act_data <= pend_data;
                act_dp   <= pend_dp;
`ifdef SVN_SEG_LZ_BLANK_EN
                lz_mask  <= lz_of(pend_data);
`endif
            end
            if (take) begin
                pend_data <= data_i;
                pend_dp   <= dp_i;
            end
            if (slot_end) begin
                cnt   <= '0;
                idx   <= wrap ? '0 : idx + 1'b1;
                state <= (DEAD_CYCLES == 0) ? ON : BLANK;
            end else begin
                cnt <= cnt + 1'b1;
                unique case (state)
                    BLANK: if (cnt + 1'b1 == CNT_ON) state <= ON;
                    ON:    state <= ON;
                endcase
            end
            seg_sel_o     <= lit ? (NUM_DIGITS'(1) << idx) : '0;
            seg_display_o <= lit ? dec_seg : PIN_OFF;
        end
    end

endmodule
